bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter CTRL_ADDR, default 32'hFFFF_FFFC, the host-only control register address.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on posedge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port h_req_ready  output  1  host request accepted this cycle.
REQ-005 SHALL have port h_req_read  input  1  host read request.
REQ-006 SHALL have port h_req_write  input  1  host write request.
REQ-007 SHALL have port h_req_address  input  32  host byte address.
REQ-008 SHALL have port h_req_data  input  32  host write data.
REQ-009 SHALL have port h_res_valid  output  1  host read data valid (one-cycle pulse).
REQ-010 SHALL have port h_res_data  output  32  host read data.
REQ-011 SHALL have port c_req_ready  output  1  core request accepted this cycle.
REQ-012 SHALL have port c_req_read  input  1  core read request.
REQ-013 SHALL have port c_req_write  input  1  core write request.
REQ-014 SHALL have port c_req_address  input  32  core byte address.
REQ-015 SHALL have port c_req_data  input  32  core write data.
REQ-016 SHALL have port c_res_valid  output  1  core read data valid (one-cycle pulse).
REQ-017 SHALL have port c_res_data  output  32  core read data.
REQ-018 SHALL have port m_req_ready  input  1  memory accepts request this cycle.
REQ-019 SHALL have port m_req_read  output  1  memory read request.
REQ-020 SHALL have port m_req_write  output  1  memory write request.
REQ-021 SHALL have port m_req_address  output  32  memory address (granted requester).
REQ-022 SHALL have port m_req_data  output  32  memory write data (granted requester).
REQ-023 SHALL have port m_res_valid  input  1  memory read data valid.
REQ-024 SHALL have port m_res_data  input  32  memory read data.
REQ-025 SHALL have port core_reset  output  1  registered reset to the core, host-controlled.

Function
REQ-026 SHALL implement states IDLE, WAIT_H, WAIT_C, LOCAL; at most one read outstanding.
REQ-027 In IDLE, SHALL combinationally route the granted requester's read/write/address/data to m_req_*; x_req_ready = granted & m_req_ready; zero added request latency.
REQ-028 Accepted write SHALL stay in IDLE (no response); accepted read SHALL go to WAIT_H/WAIT_C.
REQ-029 In WAIT_x, SHALL drive m_req_read/write 0, both x_req_ready 0; on m_res_valid pass m_res_data to owner's res_data, pulse owner's res_valid same cycle, return to IDLE.
REQ-030 Non-owner res_valid SHALL stay 0; m_res_valid in IDLE or LOCAL SHALL be ignored.
REQ-031 read and write both asserted SHALL be treated as read only.
REQ-032 Host write to CTRL_ADDR SHALL NOT reach memory: h_req_ready=1 regardless of m_req_ready, core_reset <= h_req_data[0] next edge.
REQ-033 Host read to CTRL_ADDR SHALL be accepted without memory, go LOCAL, next cycle pulse h_res_valid with h_res_data={31'b0,core_reset}, return IDLE.
REQ-034 Core accesses to CTRL_ADDR SHALL be forwarded to memory normally.
REQ-035 While core_reset=1, core requests SHALL be not granted (c_req_ready=0).

Reset
REQ-036 On reset: state IDLE, core_reset=1, all res_valid=0, RR pointer=host-last; any outstanding read abandoned, its late response ignored.

Configuration
REQ-037 BUS_ARB_RR_EN defined: on simultaneous requests, grant goes to the requester not granted last (pointer updates on each accepted request); undefined: host always wins conflicts.

Verification
REQ-038 Host write 0 to CTRL_ADDR after reset -> h_req_ready=1 with m_req_ready=0, core_reset 1->0 next cycle, no m_req_write.
REQ-039 Core read 0x100, memory responds 3 cycles later with 0xDEADBEEF -> c_res_valid one cycle, c_res_data=0xDEADBEEF, h_res_valid=0.
REQ-040 Host and core both write every cycle, m_req_ready=1 -> without macro only host accepted; with macro alternating H,C,H,C.
REQ-041 Host read pending in WAIT_H, core write asserted -> c_req_ready=0 until m_res_valid, core accepted next cycle.
REQ-042 Reset asserted in WAIT_C, m_res_valid next cycle -> no res_valid pulse, core_reset=1, state IDLE.

Source files
------------

// File: rtl/bus_arbiter.sv
// Host/core arbiter onto a single memory port, plus a host-only control register (bit 0 = core_reset).
// Define BUS_ARB_RR_EN for round-robin conflict resolution; otherwise the host always wins.
module bus_arbiter #(
    parameter logic [31:0] CTRL_ADDR = 32'hFFFF_FFFC
) (
    input  logic        clock,
    input  logic        reset,
    output logic        h_req_ready,
    input  logic        h_req_read,
    input  logic        h_req_write,
    input  logic [31:0] h_req_address,
    input  logic [31:0] h_req_data,
    output logic        h_res_valid,
    output logic [31:0] h_res_data,
    output logic        c_req_ready,
    input  logic        c_req_read,
    input  logic        c_req_write,
    input  logic [31:0] c_req_address,
    input  logic [31:0] c_req_data,
    output logic        c_res_valid,
    output logic [31:0] c_res_data,
    input  logic        m_req_ready,
    output logic        m_req_read,
    output logic        m_req_write,
    output logic [31:0] m_req_address,
    output logic [31:0] m_req_data,
    input  logic        m_res_valid,
    input  logic [31:0] m_res_data,
    output logic        core_reset
);
    typedef enum logic [1:0] {IDLE, WAIT_H, WAIT_C, LOCAL} state_t;

    state_t r_state;
    logic   r_core_reset;
    logic   w_idle;
    logic   w_h_rd, w_h_wr, w_h_any, w_h_ctrl;
    logic   w_c_rd, w_c_wr, w_c_any;
    logic   w_gnt_h, w_gnt_c, w_h_acc, w_c_acc;

    assign w_idle   = (r_state == IDLE);
    // Read wins when a requester raises read and write together.
    assign w_h_rd   = h_req_read;
    assign w_h_wr   = h_req_write & ~h_req_read;
    assign w_h_any  = w_h_rd | w_h_wr;
    assign w_h_ctrl = (h_req_address == CTRL_ADDR);
    assign w_c_rd   = c_req_read & ~r_core_reset;
    assign w_c_wr   = c_req_write & ~c_req_read & ~r_core_reset;
    assign w_c_any  = w_c_rd | w_c_wr;

`ifdef BUS_ARB_RR_EN
    logic r_last_host;

    assign w_gnt_h = w_idle & w_h_any & (~w_c_any | ~r_last_host);

    always_ff @(posedge clock) begin
        if (reset)
            r_last_host <= 1'b1;
        else if (w_h_acc)
            r_last_host <= 1'b1;
        else if (w_c_acc)
            r_last_host <= 1'b0;
    end
`else
    assign w_gnt_h = w_idle & w_h_any;
`endif
    assign w_gnt_c = w_idle & w_c_any & ~w_gnt_h;

    // Control-register accesses complete locally, so memory backpressure is irrelevant.
    assign w_h_acc     = w_gnt_h & (w_h_ctrl | m_req_ready);
    assign w_c_acc     = w_gnt_c & m_req_ready;
    assign h_req_ready = w_h_acc;
    assign c_req_ready = w_c_acc;

    always_comb begin
        m_req_read    = 1'b0;
        m_req_write   = 1'b0;
        m_req_address = h_req_address;
        m_req_data    = h_req_data;
        if (w_gnt_h && !w_h_ctrl) begin
            m_req_read  = w_h_rd;
            m_req_write = w_h_wr;
        end else if (w_gnt_c) begin
            m_req_read    = w_c_rd;
            m_req_write   = w_c_wr;
            m_req_address = c_req_address;
            m_req_data    = c_req_data;
        end
    end

    assign h_res_valid = ((r_state == WAIT_H) & m_res_valid) | (r_state == LOCAL);
    assign h_res_data  = (r_state == LOCAL) ? {31'b0, r_core_reset} : m_res_data;
    assign c_res_valid = (r_state == WAIT_C) & m_res_valid;
    assign c_res_data  = m_res_data;
    assign core_reset  = r_core_reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_core_reset <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_h_acc) begin
                        if (w_h_ctrl && w_h_wr)
                            r_core_reset <= h_req_data[0];
                        if (w_h_rd)
                            r_state <= w_h_ctrl ? LOCAL : WAIT_H;
                    end else if (w_c_acc && w_c_rd) begin
                        r_state <= WAIT_C;
                    end
                end
                WAIT_H, WAIT_C: if (m_res_valid) r_state <= IDLE;
                default:        r_state <= IDLE;
            endcase
        end
    end
endmodule
